// File: rtl/operand_fetch.sv
// Serial operand fetch / writeback sequencer around an external multi-cycle ALU.
// Optional feature macro: IMMEDIATE_OPERAND_EN (imm_sel picks sign-extended imm11 for alu_b).
module operand_fetch #(
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [4:0]  alu_opcode,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_enable,
  input  logic [31:0] alu_result,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } state_t;

  localparam logic [3:0] LAT4 = 4'(ALU_LAT);

  // Handshake: an instruction is taken on a rising edge where instr_valid && instr_ready;
  // instr_ready is high only in IDLE and nothing offered outside IDLE is remembered.

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [4:0]  rd_q;
  logic [31:0] rf [32];

  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] op_a;
  logic [31:0] op_b;

  assign rs1 = instr[21:17];
  assign rs2 = instr[16:12];

  always_comb begin
    op_a = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
    op_b = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
`ifdef IMMEDIATE_OPERAND_EN
    if (instr[11]) op_b = {{21{instr[10]}}, instr[10:0]};
`endif
  end

`ifndef IMMEDIATE_OPERAND_EN
  logic unused_imm;
  assign unused_imm = ^instr[11:0];
`endif

  assign instr_ready = (state == IDLE);
  assign dbg_state   = state;
  assign dbg_data    = (dbg_addr == 5'd0) ? 32'd0 : rf[dbg_addr];

  // Operands are loaded on the accepting edge so they are already valid during ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      rd_q       <= 5'd0;
      alu_opcode <= 5'd0;
      alu_a      <= 32'd0;
      alu_b      <= 32'd0;
      alu_enable <= 1'b0;
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else begin
      alu_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            rd_q       <= instr[26:22];
            alu_opcode <= instr[31:27];
            alu_a      <= op_a;
            alu_b      <= op_b;
            alu_enable <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= LAT4;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt <= 4'd1) begin
            wait_cnt <= 4'd0;
            state    <= WB;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        WB: begin
          if (rd_q != 5'd0) rf[rd_q] <= alu_result;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed + randomized bench for operand_fetch against a register-file reference model.
module tb_operand_fetch;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        instr_ready;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_enable;
  logic [31:0] alu_result;
  logic [4:0]  dbg_addr = 5'd0;
  logic [31:0] dbg_data;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  logic [31:0] alu_const = 32'd0;
  logic [31:0] m_rf [32];
  int cyc = 0;
  int en_cnt = 0;
  int acc_q[$];

  operand_fetch #(.ALU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_enable(alu_enable), .alu_result(alu_result), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: opcode 31 returns a bench-chosen constant.
  function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] k);
    case (op)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a ^ b;
      5'd3:    return a & b;
      5'd31:   return k;
      default: return a | b;
    endcase
  endfunction

  always_comb alu_result = alu_fn(alu_opcode, alu_a, alu_b, alu_const);

  always @(posedge clk) begin
    if (rst_n && instr_valid && instr_ready) acc_q.push_back(cyc);
    if (alu_enable) en_cnt <= en_cnt + 1;
    cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
  endtask

  // Runs one instruction from an IDLE negedge to the IDLE negedge after its writeback.
  task automatic run_instr(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic imm_sel, input logic [10:0] imm,
                           input logic hold);
    int n = 0;
    logic [31:0] exp_a, exp_b, res;
    logic en_wait = 1'b0;
    logic rdy_busy = 1'b0;
    while (!instr_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ready_idle", {31'd0, instr_ready}, 32'd1);
    exp_a = m_rf[rs1];
    exp_b = m_rf[rs2];
`ifdef IMMEDIATE_OPERAND_EN
    if (imm_sel) exp_b = {{21{imm[10]}}, imm};
`endif
    instr = {op, rd, rs1, rs2, imm_sel, imm};
    instr_valid = 1'b1;
    @(negedge clk);
    chk("issue_en", {31'd0, alu_enable}, 32'd1);
    chk("issue_op", {27'd0, alu_opcode}, {27'd0, op});
    chk("issue_a", alu_a, exp_a);
    chk("issue_b", alu_b, exp_b);
    if (!hold) instr_valid = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      if (alu_enable) en_wait = 1'b1;
      if (instr_ready) rdy_busy = 1'b1;
    end
    chk("wait_en_low", {31'd0, en_wait}, 32'd0);
    chk("wait_not_ready", {31'd0, rdy_busy}, 32'd0);
    @(negedge clk);
    chk("wb_not_ready", {31'd0, instr_ready}, 32'd0);
    res = alu_fn(op, exp_a, exp_b, alu_const);
    dbg_addr = rd;
    @(negedge clk);
    if (rd != 5'd0) m_rf[rd] = res;
    chk("wb_data", dbg_data, m_rf[rd]);
    chk("back_idle", {31'd0, instr_ready}, 32'd1);
  endtask

  initial begin
    int e0;
    clear_model();
    // Reset state
    #12;
    chk("rst_en", {31'd0, alu_enable}, 32'd0);
    chk("rst_op", {27'd0, alu_opcode}, 32'd0);
    chk("rst_a", alu_a, 32'd0);
    chk("rst_b", alu_b, 32'd0);
    dbg_addr = 5'd17;
    #1;
    chk("rst_rf", dbg_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);

    // Dependency: r1 = 5, then rs1 = rs2 = 1 right after
    alu_const = 32'd5;
    run_instr(5'd31, 5'd1, 5'd0, 5'd0, 1'b0, 11'd0, 1'b0);
    run_instr(5'd0, 5'd9, 5'd1, 5'd1, 1'b0, 11'd0, 1'b0);

    // r0 protection
    alu_const = 32'hDEADBEEF;
    run_instr(5'd31, 5'd0, 5'd1, 5'd9, 1'b0, 11'd0, 1'b0);
    run_instr(5'd0, 5'd4, 5'd0, 5'd9, 1'b0, 11'd0, 1'b0);

    // imm_sel behaviour (expected alu_b follows the build's configuration)
    alu_const = 32'h0F0F0F0F;
    run_instr(5'd31, 5'd2, 5'd0, 5'd0, 1'b0, 11'd0, 1'b0);
    run_instr(5'd0, 5'd1, 5'd0, 5'd2, 1'b1, 11'h7FF, 1'b0);
    run_instr(5'd0, 5'd10, 5'd0, 5'd2, 1'b1, 11'h400, 1'b0);

    // Back-to-back with instr_valid held
    acc_q.delete();
    e0 = en_cnt;
    run_instr(5'd0, 5'd5, 5'd9, 5'd2, 1'b0, 11'd0, 1'b1);
    run_instr(5'd2, 5'd6, 5'd5, 5'd9, 1'b0, 11'd0, 1'b1);
    run_instr(5'd1, 5'd7, 5'd6, 5'd5, 1'b0, 11'd0, 1'b0);
    instr_valid = 1'b0;
    chk("b2b_accepts", acc_q.size(), 32'd3);
    if (acc_q.size() == 3) begin
      chk("b2b_gap1", acc_q[1] - acc_q[0], LAT + 3);
      chk("b2b_gap2", acc_q[2] - acc_q[1], LAT + 3);
    end
    chk("b2b_enables", en_cnt - e0, 32'd3);
    for (int r = 5; r < 8; r++) begin
      dbg_addr = 5'(r);
      #1;
      chk("b2b_write", dbg_data, m_rf[r]);
    end

    // Randomized instructions
    for (int k = 0; k < 24; k++) begin
      logic [4:0] op;
      op = ($urandom_range(0, 5) == 5) ? 5'd31 : 5'($urandom_range(0, 4));
      alu_const = $urandom;
      run_instr(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                11'($urandom_range(0, 2047)), 1'b0);
    end
    for (int r = 0; r < 32; r++) begin
      dbg_addr = 5'(r);
      #1;
      chk("rf_sweep", dbg_data, m_rf[r]);
    end

    // Reset mid-WAIT with rd=3 pending
    alu_const = 32'h13572468;
    run_instr(5'd31, 5'd3, 5'd0, 5'd0, 1'b0, 11'd0, 1'b0);
    alu_const = 32'hCAFEF00D;
    instr = {5'd31, 5'd3, 5'd0, 5'd0, 1'b0, 11'd0};
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("mid_wait_state", {30'd0, dbg_state}, 32'd2);
    rst_n = 1'b0;
    #2;
    chk("mr_ready", {31'd0, instr_ready}, 32'd1);
    chk("mr_en", {31'd0, alu_enable}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    repeat (LAT + 3) @(negedge clk);
    dbg_addr = 5'd3;
    #1;
    chk("mr_rf3", dbg_data, 32'd0);
    chk("mr_idle", {30'd0, dbg_state}, 32'd0);
    chk("mr_a", alu_a, 32'd0);
    run_instr(5'd0, 5'd11, 5'd3, 5'd3, 1'b0, 11'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
